// File: rtl/serial_add_ctrl.sv
// Bit-serial addition sequencer driving a registered 1-bit full adder (2-cycle latency).
// Operands are fed LSB first and each step's carry is chained into the next step's Cin.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             fa_A,
  output logic             fa_B,
  output logic             fa_Cin,
  input  logic             fa_S,
  input  logic             fa_Cout
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_WAIT   = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_cin;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_shadow;
  logic             r_carry_hold;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_fa_a;
  logic             w_fa_b;
  logic             w_fa_cin;
  logic             w_last;
  logic [IW-1:0]    w_idx_prev;
  logic [WIDTH-1:0] w_final;

  assign w_last     = (r_idx == LAST_IDX);
  assign w_idx_prev = r_idx - IW'(1);

  // Next-state decode and adder drive; WAIT reuses the carry captured during DRIVE.
  always_comb begin
    w_next   = r_state;
    w_fa_a   = 1'b0;
    w_fa_b   = 1'b0;
    w_fa_cin = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = S_DRIVE;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_DRIVE: begin
        w_fa_a = r_a[r_idx];
        w_fa_b = r_b[r_idx];
        if (r_idx == IW'(0)) begin
          w_fa_cin = r_cin;
        end else begin
          w_fa_cin = fa_Cout;
        end
        w_next = S_WAIT;
      end
      S_WAIT: begin
        w_fa_a   = r_a[r_idx];
        w_fa_b   = r_b[r_idx];
        w_fa_cin = r_carry_hold;
        if (w_last) begin
          w_next = S_FINISH;
        end else begin
          w_next = S_DRIVE;
        end
      end
      S_FINISH: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // The last bit's sum comes straight from the adder; the lower bits from the shadow.
  always_comb begin
    w_final              = r_shadow;
    w_final[WIDTH-1]     = fa_S;
  end

  // State register plus operand, index, shadow and result registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= S_IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_cin        <= 1'b0;
      r_idx        <= '0;
      r_shadow     <= '0;
      r_carry_hold <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_sum        <= '0;
      r_cout       <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != S_IDLE);
      r_done  <= (r_state == S_FINISH);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a   <= op_a;
            r_b   <= op_b;
            r_cin <= cin;
            r_idx <= '0;
          end
        end
        S_DRIVE: begin
          r_carry_hold <= w_fa_cin;
          if (r_idx != IW'(0)) begin
            r_shadow[w_idx_prev] <= fa_S;
          end
        end
        S_WAIT: begin
          if (!w_last) begin
            r_idx <= r_idx + IW'(1);
          end
        end
        S_FINISH: begin
          r_sum  <= w_final;
          r_cout <= fa_Cout;
        end
        default: begin
          r_idx <= '0;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign sum    = r_sum;
  assign cout   = r_cout;
  assign fa_A   = w_fa_a;
  assign fa_B   = w_fa_b;
  assign fa_Cin = w_fa_cin;

endmodule
